serdes_gearbox_tx: RTL and testbench



---
 rtl/serdes_pkg.sv | 21 ++
 rtl/serdes_gearbox_lane.sv | 34 +++
 rtl/serdes_gearbox_tx.sv | 161 ++++++++++++++++
 tb/tb_serdes_gearbox_tx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/serdes_pkg.sv
// rtl/serdes_pkg.sv - shared constants and helpers for the serdes transmit gearbox
package serdes_pkg;

  localparam logic [6:0] PRBS7_TAPS = 7'h60;
  localparam logic [6:0] PRBS7_SEED = 7'h7F;

  // Fibonacci LFSR for x^7+x^6+1; each step shifts the feedback bit into bit 0.
  function automatic logic [6:0] prbs7_next(input logic [6:0] state, input int nbits);
    logic [6:0] s;
    s = state;
    for (int i = 0; i < nbits; i++) begin
      s = {s[5:0], ^(s & PRBS7_TAPS)};
    end
    return s;
  endfunction

  function automatic bit gearbox_cfg_ok(input int in_w, input int out_w);
    return (out_w > 0) && (in_w >= out_w) && ((in_w % out_w) == 0);
  endfunction

endpackage

// File: rtl/serdes_gearbox_lane.sv
// rtl/serdes_gearbox_lane.sv - one lane's shift register, reloaded or shifted by OUT_W each cycle
module serdes_gearbox_lane #(
  parameter int              IN_W      = 10,
  parameter int              OUT_W     = 2,
  parameter logic [IN_W-1:0] IDLE_WORD = 10'h354
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [IN_W-1:0]  load_word,
  output logic [OUT_W-1:0] o_slice
);

  logic [IN_W-1:0] sh_q;
  logic [IN_W-1:0] sh_d;

  always_comb begin
    sh_d = sh_q >> OUT_W;
    if (load) begin
      sh_d = load_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q <= IDLE_WORD;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign o_slice = sh_q[OUT_W-1:0];

endmodule

// File: rtl/serdes_gearbox_tx.sv
// rtl/serdes_gearbox_tx.sv - multi-lane transmit gearbox with one-word hold and idle substitution
// Optional PRBS7 test pattern source enabled by SERDES_GEARBOX_PRBS_EN.
module serdes_gearbox_tx
  import serdes_pkg::*;
#(
  parameter int              CHANNELS  = 3,
  parameter int              IN_W      = 10,
  parameter int              OUT_W     = 2,
  parameter logic [IN_W-1:0] IDLE_WORD = 10'h354,
  parameter int              CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [CHANNELS*IN_W-1:0]  i_data,
`ifdef SERDES_GEARBOX_PRBS_EN
  input  logic                      i_prbs_mode,
`endif
  output logic [CHANNELS*OUT_W-1:0] o_data,
  output logic                      o_active,
  output logic                      o_underflow,
  output logic [CNT_W-1:0]          o_underflow_count
);

  localparam int R = IN_W / OUT_W;
  localparam int SLOT_W = (R > 1) ? $clog2(R) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(R - 1);

  if (!gearbox_cfg_ok(IN_W, OUT_W)) begin : g_cfg_err
    $error("serdes_gearbox_tx: IN_W must be a nonzero multiple of OUT_W");
  end

  logic [SLOT_W-1:0]        slot_q, slot_d;
  logic [CHANNELS*IN_W-1:0] hold_q, hold_d;
  logic                     hold_v_q, hold_v_d;
  logic                     active_q, active_d;
  logic                     underflow_q, underflow_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [CHANNELS*IN_W-1:0] load_word;
  logic                     reload;
  logic                     accept;
  logic                     idle_load;

`ifdef SERDES_GEARBOX_PRBS_EN
  logic [6:0]      prbs_q, prbs_d;
  logic [IN_W-1:0] prbs_word;
  logic [6:0]      prbs_s;

  // Word bit i is the i-th generated LFSR bit, so the pattern is sent in generation order.
  always_comb begin
    prbs_s = prbs_q;
    prbs_word = '0;
    for (int i = 0; i < IN_W; i++) begin
      prbs_s = prbs7_next(prbs_s, 1);
      prbs_word[i] = prbs_s[0];
    end
    prbs_d = (reload && i_prbs_mode) ? prbs_s : prbs_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prbs_q <= PRBS7_SEED;
    end else begin
      prbs_q <= prbs_d;
    end
  end
`endif

  assign reload = (slot_q == SLOT_LAST);
  assign o_ready = !hold_v_q || reload;
  assign accept = i_valid && o_ready;

  always_comb begin
    slot_d      = reload ? '0 : slot_q + 1'b1;
    hold_d      = hold_q;
    hold_v_d    = hold_v_q;
    active_d    = active_q;
    underflow_d = 1'b0;
    count_d     = count_q;
    load_word   = {CHANNELS{IDLE_WORD}};
    idle_load   = 1'b0;

    if (reload) begin
      if (hold_v_q) begin
        load_word = hold_q;
        hold_v_d  = accept;
        if (accept) begin
          hold_d = i_data;
        end
      end else if (accept) begin
        load_word = i_data;
      end else begin
        idle_load = 1'b1;
      end
    end else if (accept) begin
      hold_d   = i_data;
      hold_v_d = 1'b1;
    end

`ifdef SERDES_GEARBOX_PRBS_EN
    if (i_prbs_mode) begin
      idle_load = 1'b0;
      if (reload) begin
        load_word = {CHANNELS{prbs_word}};
      end
    end
`endif

    if (reload) begin
      active_d    = !idle_load;
      underflow_d = idle_load;
      if (idle_load && (count_q != '1)) begin
        count_d = count_q + 1'b1;
      end
    end

`ifdef SERDES_GEARBOX_PRBS_EN
    if (i_prbs_mode) begin
      active_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q      <= '0;
      hold_q      <= '0;
      hold_v_q    <= 1'b0;
      active_q    <= 1'b0;
      underflow_q <= 1'b0;
      count_q     <= '0;
    end else begin
      slot_q      <= slot_d;
      hold_q      <= hold_d;
      hold_v_q    <= hold_v_d;
      active_q    <= active_d;
      underflow_q <= underflow_d;
      count_q     <= count_d;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    serdes_gearbox_lane #(
      .IN_W      (IN_W),
      .OUT_W     (OUT_W),
      .IDLE_WORD (IDLE_WORD)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .load      (reload),
      .load_word (load_word[k*IN_W +: IN_W]),
      .o_slice   (o_data[k*OUT_W +: OUT_W])
    );
  end

  assign o_active          = active_q;
  assign o_underflow       = underflow_q;
  assign o_underflow_count = count_q;

endmodule

// File: tb/tb_serdes_gearbox_tx.sv
// tb/tb_serdes_gearbox_tx.sv - directed scoreboard bench for serdes_gearbox_tx
module tb_serdes_gearbox_tx;

  localparam int CH = 3;
  localparam int IN_W = 10;
  localparam int OUT_W = 2;
  localparam int R = IN_W / OUT_W;
  localparam logic [IN_W-1:0] IDLE = 10'h354;

  typedef struct packed {
    logic [CH*OUT_W-1:0] data;
    logic                act;
    logic                uf;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   i_valid;
  logic                   o_ready;
  logic [CH*IN_W-1:0]     i_data;
  logic [CH*OUT_W-1:0]    o_data;
  logic                   o_active;
  logic                   o_underflow;
  logic [15:0]            o_underflow_count;

  logic                   rst_s;
  logic                   i_valid_s;
  logic [CH*IN_W-1:0]     i_data_s;
  logic                   o_ready_s;
  logic [CH*OUT_W-1:0]    o_data_s;
  logic                   o_active_s;
  logic                   o_underflow_s;
  logic [3:0]             o_underflow_count_s;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  serdes_gearbox_tx #(
    .CHANNELS(CH), .IN_W(IN_W), .OUT_W(OUT_W), .IDLE_WORD(IDLE), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .o_data(o_data), .o_active(o_active), .o_underflow(o_underflow),
    .o_underflow_count(o_underflow_count)
  );

  serdes_gearbox_tx #(
    .CHANNELS(CH), .IN_W(IN_W), .OUT_W(OUT_W), .IDLE_WORD(IDLE), .CNT_W(4)
  ) dut_sat (
    .clk(clk), .reset(rst_s), .i_valid(i_valid_s), .o_ready(o_ready_s), .i_data(i_data_s),
    .o_data(o_data_s), .o_active(o_active_s), .o_underflow(o_underflow_s),
    .o_underflow_count(o_underflow_count_s)
  );

  function automatic logic [CH*IN_W-1:0] mk(input logic [IN_W-1:0] l0, input logic [IN_W-1:0] l1,
                                            input logic [IN_W-1:0] l2);
    return {l2, l1, l0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [CH*IN_W-1:0] w, input logic act, input logic uf_first);
    exp_t e;
    for (int j = 0; j < R; j++) begin
      for (int k = 0; k < CH; k++) begin
        e.data[k*OUT_W +: OUT_W] = w[k*IN_W + j*OUT_W +: OUT_W];
      end
      e.act = act;
      e.uf  = uf_first && (j == 0);
      sb.push_back(e);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL sb_empty: observed no expected entry, expected one queued");
    end else begin
      e = sb.pop_front();
      chk("o_data", 32'(o_data), 32'(e.data));
      chk("o_active", 32'(o_active), 32'(e.act));
      chk("o_underflow", 32'(o_underflow), 32'(e.uf));
    end
  endtask

  task automatic tick(input logic exp_rdy);
    chk("o_ready", 32'(o_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    logic [CH*IN_W-1:0] idle3, w1, wa, wb, wc, wd, we, wf;
    idle3 = {CH{IDLE}};
    w1 = mk(10'h2A5, 10'h0F3, 10'h1C8);
    wa = mk(10'h3FF, 10'h000, 10'h2AA);
    wb = mk(10'h000, 10'h3FF, 10'h155);
    wc = mk(10'h155, 10'h2AA, 10'h3C3);
    wd = mk(10'h123, 10'h0AB, 10'h3E1);
    we = mk(10'h2DB, 10'h16C, 10'h05A);
    wf = mk(10'h3FF, 10'h3FF, 10'h3FF);

    reset = 1'b1; rst_s = 1'b1;
    i_valid = 1'b0; i_data = '0;
    i_valid_s = 1'b0; i_data_s = '0;

    // Reset state: idle word already in sh, no underflow pulse for it.
    push_word(idle3, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_out();
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_count", 32'(o_underflow_count), 32'd0);
    reset = 1'b0; rst_s = 1'b0;
    repeat (R - 1) tick(1'b1);

    // Underflow stream: idle words, pulse on first slice, count 1,2,3.
    for (int i = 1; i <= 3; i++) begin
      push_word(idle3, 1'b0, 1'b1);
      tick(1'b1);
      chk("uf_count", 32'(o_underflow_count), 32'(i));
      repeat (R - 1) tick(1'b1);
    end

    // Latency 1: word accepted at last slot with hold empty.
    i_valid = 1'b1; i_data = w1;
    push_word(w1, 1'b1, 1'b0);
    tick(1'b1);
    i_valid = 1'b0;
    repeat (R - 1) tick(1'b1);

    // Continuous valid: bypass A, B into hold, C accepted while B drains.
    i_valid = 1'b1; i_data = wa;
    push_word(wa, 1'b1, 1'b0);
    tick(1'b1);
    i_data = wb;
    push_word(wb, 1'b1, 1'b0);
    tick(1'b1);
    i_data = wc;
    push_word(wc, 1'b1, 1'b0);
    repeat (3) tick(1'b0);
    tick(1'b1);
    i_valid = 1'b0;
    repeat (R - 1) tick(1'b0);
    tick(1'b1);
    chk("count_frozen", 32'(o_underflow_count), 32'd3);
    repeat (R - 1) tick(1'b1);

    // Accept at slot 1 goes to hold; second word at last slot lands in hold.
    push_word(idle3, 1'b0, 1'b1);
    tick(1'b1);
    tick(1'b1);
    i_valid = 1'b1; i_data = wd;
    push_word(wd, 1'b1, 1'b0);
    tick(1'b1);
    i_valid = 1'b0;
    tick(1'b0);
    tick(1'b0);
    i_valid = 1'b1; i_data = we;
    push_word(we, 1'b1, 1'b0);
    tick(1'b1);
    i_valid = 1'b0;
    repeat (R - 1) tick(1'b0);
    tick(1'b1);
    chk("count_after_d", 32'(o_underflow_count), 32'd4);

    // Fill hold with F, then reset at slot 2: F must never appear.
    i_valid = 1'b1; i_data = wf;
    tick(1'b1);
    i_valid = 1'b0;
    tick(1'b0);
    reset = 1'b1;
    sb.delete();
    push_word(idle3, 1'b0, 1'b0);
    tick(1'b0);
    chk("midrst_ready", 32'(o_ready), 32'd1);
    chk("midrst_count", 32'(o_underflow_count), 32'd0);
    reset = 1'b0;
    repeat (R - 1) tick(1'b1);
    push_word(idle3, 1'b0, 1'b1);
    tick(1'b1);
    chk("post_rst_count", 32'(o_underflow_count), 32'd1);
    repeat (R - 1) tick(1'b1);

    // 100 more idle cycles: 20 further reloads on the main instance.
    repeat (100) @(posedge clk);
    #1;
    chk("long_count", 32'(o_underflow_count), 32'd21);
    chk("sat_count", 32'(o_underflow_count_s), 32'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
